microwave_ctrl: RTL and testbench

MICROWAVE_CTRL -- requirements
Module: microwave_ctrl

---
 rtl/microwave_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_microwave_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/microwave_ctrl.sv
// Microwave oven sequencer: selects cook time, drives an external countdown timer,
// duty-cycles the magnetron by power level and sounds the end-of-cook buzzer.
module microwave_ctrl #(
    parameter int unsigned PRESCALE = 100_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       btn_pause,
    input  logic       door_open,
    input  logic [1:0] preset,
    input  logic [6:0] man_min,
    input  logic [6:0] man_sec,
    input  logic [3:0] power,
    input  logic       tmr_done,
    output logic       tmr_start,
    output logic       tmr_stop,
    output logic       tmr_pause,
    output logic [6:0] tmr_min,
    output logic [6:0] tmr_sec,
    output logic       magnetron,
    output logic       lamp,
    output logic       beep,
    output logic [2:0] state
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        COOK   = 3'd1,
        PAUSED = 3'd2,
        BEEP   = 3'd3
    } state_t;

    // Preset cook times packed as {minutes, seconds}; 0 means manual entry.
    function automatic logic [13:0] preset_time(input logic [1:0] sel);
        case (sel)
            2'd1:    preset_time = {7'd2, 7'd30};
            2'd2:    preset_time = {7'd5, 7'd0};
            2'd3:    preset_time = {7'd0, 7'd30};
            default: preset_time = {7'd0, 7'd0};
        endcase
    endfunction

    state_t         state_r, nxt_s;
    logic [PW-1:0]  presc_r;
    logic [3:0]     phase_r, power_r, power_clamp_s;
    logic [2:0]     beep_cnt_r;
    logic           beep_r, tick_s, time_nz_s;
    logic           start_p_s, stop_p_s, pause_p_s;
    logic           tmr_start_r, tmr_stop_r, tmr_pause_r;
    logic [6:0]     min_r, sec_r, sel_min_s, sel_sec_s;

    // Time source selection with manual clamping.
    always_comb begin
        if (preset != 2'd0) begin
            {sel_min_s, sel_sec_s} = preset_time(preset);
        end else begin
            sel_min_s = (man_min > 7'd99) ? 7'd99 : man_min;
            sel_sec_s = (man_sec > 7'd59) ? 7'd59 : man_sec;
        end
    end

    assign time_nz_s     = (sel_min_s != 7'd0) || (sel_sec_s != 7'd0);
    assign power_clamp_s = ((power == 4'd0) || (power > 4'd10)) ? 4'd10 : power;
    assign tick_s        = (presc_r == PRESC_MAX);

    // Next-state and timer-pulse decode; COOK priority is stop > done > door > pause.
    always_comb begin
        nxt_s     = state_r;
        start_p_s = 1'b0;
        stop_p_s  = 1'b0;
        pause_p_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (btn_start && !door_open && time_nz_s) begin
                    nxt_s     = COOK;
                    start_p_s = 1'b1;
                end else begin
                    nxt_s = IDLE;
                end
            end
            COOK: begin
                if (btn_stop) begin
                    nxt_s    = IDLE;
                    stop_p_s = 1'b1;
                end else if (tmr_done) begin
                    nxt_s = BEEP;
                end else if (door_open || btn_pause) begin
                    nxt_s     = PAUSED;
                    pause_p_s = 1'b1;
                end else begin
                    nxt_s = COOK;
                end
            end
            PAUSED: begin
                if (btn_stop) begin
                    nxt_s    = IDLE;
                    stop_p_s = 1'b1;
                end else if (tmr_done) begin
                    nxt_s = IDLE;
                end else if ((btn_start || btn_pause) && !door_open) begin
                    nxt_s     = COOK;
                    pause_p_s = 1'b1;
                end else begin
                    nxt_s = PAUSED;
                end
            end
            BEEP: begin
                if (btn_start || btn_stop || btn_pause || door_open) begin
                    nxt_s = IDLE;
                end else if (tick_s && (beep_cnt_r == 3'd5)) begin
                    nxt_s = IDLE;
                end else begin
                    nxt_s = BEEP;
                end
            end
            default: nxt_s = IDLE;
        endcase
    end

    // State, timer pulses and the time value handed to the timer.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= IDLE;
            tmr_start_r <= 1'b0;
            tmr_stop_r  <= 1'b0;
            tmr_pause_r <= 1'b0;
            min_r       <= 7'd0;
            sec_r       <= 7'd0;
        end else begin
            state_r     <= nxt_s;
            tmr_start_r <= start_p_s;
            tmr_stop_r  <= stop_p_s;
            tmr_pause_r <= pause_p_s;
            if ((state_r == IDLE) || (nxt_s == IDLE)) begin
                min_r <= sel_min_s;
                sec_r <= sel_sec_s;
            end
        end
    end

    // Second prescaler: restarts on entry to COOK/BEEP, frozen elsewhere.
    always_ff @(posedge clock) begin
        if (reset) begin
            presc_r <= '0;
        end else if ((nxt_s != state_r) && ((nxt_s == COOK) || (nxt_s == BEEP))) begin
            presc_r <= '0;
        end else if ((state_r == COOK) || (state_r == BEEP)) begin
            presc_r <= tick_s ? '0 : presc_r + PW'(1'b1);
        end
    end

    // Duty phase and latched power; phase survives PAUSED so resume continues the pattern.
    always_ff @(posedge clock) begin
        if (reset) begin
            phase_r <= 4'd0;
            power_r <= 4'd0;
        end else if ((state_r == IDLE) && (nxt_s == COOK)) begin
            phase_r <= 4'd0;
            power_r <= power_clamp_s;
        end else if ((state_r == COOK) && tick_s) begin
            phase_r <= (phase_r == 4'd9) ? 4'd0 : phase_r + 4'd1;
        end
    end

    // Buzzer: starts high on entry and toggles per tick for six ticks.
    always_ff @(posedge clock) begin
        if (reset) begin
            beep_r     <= 1'b0;
            beep_cnt_r <= 3'd0;
        end else if ((state_r != BEEP) && (nxt_s == BEEP)) begin
            beep_r     <= 1'b1;
            beep_cnt_r <= 3'd0;
        end else if (nxt_s != BEEP) begin
            beep_r <= 1'b0;
        end else if (tick_s) begin
            beep_r     <= ~beep_r;
            beep_cnt_r <= beep_cnt_r + 3'd1;
        end
    end

    assign tmr_start = tmr_start_r;
    assign tmr_stop  = tmr_stop_r;
    assign tmr_pause = tmr_pause_r;
    assign tmr_min   = min_r;
    assign tmr_sec   = sec_r;
    assign beep      = beep_r;
    assign state     = state_r;
    // Door term bypasses the registers so the heater cuts in the cycle the door opens.
    assign magnetron = (state_r == COOK) && (phase_r < power_r) && !door_open;
    assign lamp      = (state_r == COOK) || (state_r == PAUSED) || door_open;

endmodule

// File: tb/tb_microwave_ctrl.sv
// Directed and randomized bench for microwave_ctrl (PRESCALE=4) against a
// cycle-count reference model of the cooking sequence.
module tb_microwave_ctrl;

    logic       clock = 1'b0;
    logic       reset, btn_start, btn_stop, btn_pause, door_open, tmr_done;
    logic [1:0] preset;
    logic [6:0] man_min, man_sec;
    logic [3:0] power;
    logic       tmr_start, tmr_stop, tmr_pause, magnetron, lamp, beep;
    logic [6:0] tmr_min, tmr_sec;
    logic [2:0] state;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: mode 0 idle, 1 cook, 2 paused, 3 beep.
    int m_state, m_min, m_sec, m_pw, m_ticks, m_seg;
    bit m_start, m_stop, m_pause, m_beep;

    microwave_ctrl #(.PRESCALE(4)) dut (
        .clock(clock), .reset(reset), .btn_start(btn_start), .btn_stop(btn_stop),
        .btn_pause(btn_pause), .door_open(door_open), .preset(preset),
        .man_min(man_min), .man_sec(man_sec), .power(power), .tmr_done(tmr_done),
        .tmr_start(tmr_start), .tmr_stop(tmr_stop), .tmr_pause(tmr_pause),
        .tmr_min(tmr_min), .tmr_sec(tmr_sec), .magnetron(magnetron), .lamp(lamp),
        .beep(beep), .state(state)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        int smin, ssec, ns;
        bit tk;
        if (reset) begin
            m_state = 0; m_min = 0; m_sec = 0; m_pw = 0; m_ticks = 0; m_seg = 0;
            m_start = 0; m_stop = 0; m_pause = 0; m_beep = 0;
            return;
        end
        case (preset)
            2'd1: begin smin = 2; ssec = 30; end
            2'd2: begin smin = 5; ssec = 0; end
            2'd3: begin smin = 0; ssec = 30; end
            default: begin
                smin = (int'(man_min) > 99) ? 99 : int'(man_min);
                ssec = (int'(man_sec) > 59) ? 59 : int'(man_sec);
            end
        endcase
        ns = m_state;
        m_start = 0; m_stop = 0; m_pause = 0;
        tk = (m_state == 1 || m_state == 3) && (m_seg % 4 == 3);
        if (m_state == 0) begin
            if (btn_start && !door_open && (smin != 0 || ssec != 0)) begin
                ns = 1; m_start = 1; m_ticks = 0;
                m_pw = (power == 0 || power > 10) ? 10 : int'(power);
            end
        end else if (m_state == 1) begin
            if (btn_stop) begin ns = 0; m_stop = 1; end
            else if (tmr_done) ns = 3;
            else if (door_open || btn_pause) begin ns = 2; m_pause = 1; end
        end else if (m_state == 2) begin
            if (btn_stop) begin ns = 0; m_stop = 1; end
            else if (tmr_done) ns = 0;
            else if ((btn_start || btn_pause) && !door_open) begin ns = 1; m_pause = 1; end
        end else begin
            if (btn_start || btn_stop || btn_pause || door_open) ns = 0;
            else if (m_seg == 23) ns = 0;
        end
        if (m_state == 1 && tk) m_ticks++;
        if (ns != m_state && (ns == 1 || ns == 3)) m_seg = 0;
        else if (m_state == 1 || m_state == 3) m_seg++;
        if (m_state == 0 || ns == 0) begin m_min = smin; m_sec = ssec; end
        m_beep = (ns == 3) && ((m_seg / 4) % 2 == 0);
        m_state = ns;
    endtask

    task automatic clk_step();
        @(posedge clock);
        model_step();
        #1;
        n_vec++;
        chk("state", 8'(state), 8'(m_state));
        chk("tmr_start", 8'(tmr_start), 8'(m_start));
        chk("tmr_stop", 8'(tmr_stop), 8'(m_stop));
        chk("tmr_pause", 8'(tmr_pause), 8'(m_pause));
        chk("tmr_min", 8'(tmr_min), 8'(m_min));
        chk("tmr_sec", 8'(tmr_sec), 8'(m_sec));
        chk("magnetron", 8'(magnetron),
            8'((m_state == 1) && ((m_ticks % 10) < m_pw) && !door_open));
        chk("lamp", 8'(lamp), 8'((m_state == 1) || (m_state == 2) || door_open));
        chk("beep", 8'(beep), 8'(m_beep));
    endtask

    task automatic pulse(input logic st, input logic sp, input logic pa, input logic dn);
        btn_start = st; btn_stop = sp; btn_pause = pa; tmr_done = dn;
        clk_step();
        btn_start = 1'b0; btn_stop = 1'b0; btn_pause = 1'b0; tmr_done = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) clk_step();
    endtask

    initial begin
        int highs;
        reset = 1'b1; btn_start = 1'b0; btn_stop = 1'b0; btn_pause = 1'b0;
        tmr_done = 1'b0; door_open = 1'b0; preset = 2'd1;
        man_min = 7'd0; man_sec = 7'd0; power = 4'd5;
        #1;
        run(2);
        reset = 1'b0;
        run(3);

        // Preset popcorn start and stop
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        chk("req022_start", 8'(tmr_start), 8'd1);
        chk("req022_min", 8'(tmr_min), 8'd2);
        chk("req022_sec", 8'(tmr_sec), 8'd30);
        preset = 2'd2;
        run(6);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        run(3);

        // Manual clamp and power 0 -> continuous heat
        preset = 2'd0; man_min = 7'd120; man_sec = 7'd75; power = 4'd0;
        run(2);
        chk("req023_min", 8'(tmr_min), 8'd99);
        chk("req023_sec", 8'(tmr_sec), 8'd59);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        run(50);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);

        // Power 3 duty: 12 cycles on out of 40
        power = 4'd3; man_min = 7'd1; man_sec = 7'd0;
        run(2);
        highs = 0;
        btn_start = 1'b1;
        clk_step();
        btn_start = 1'b0;
        highs += int'(magnetron);
        for (int i = 0; i < 39; i++) begin
            clk_step();
            highs += int'(magnetron);
        end
        chk("req024_duty", 8'(highs), 8'd12);
        run(45);

        // Door open mid-cook, ignored start, resume with pause
        door_open = 1'b1;
        #1;
        chk("req025_heat_off", 8'(magnetron), 8'd0);
        run(3);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        run(2);
        door_open = 1'b0;
        run(2);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        run(20);

        // Done + pause together -> full beep sequence
        pulse(1'b0, 1'b0, 1'b1, 1'b1);
        run(30);

        // Stop + done together
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        run(5);
        pulse(1'b0, 1'b1, 1'b0, 1'b1);
        run(3);

        // Zero time and open door starts are ignored
        man_min = 7'd0; man_sec = 7'd0;
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        man_sec = 7'd10; door_open = 1'b1;
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        door_open = 1'b0;
        run(2);

        // Beep aborted by a button; paused timer done; reset mid-cook
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        run(3);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        run(6);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        run(2);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        run(2);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        run(2);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        run(5);
        reset = 1'b1;
        clk_step();
        reset = 1'b0;
        run(3);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            btn_start = ($urandom_range(0, 9) == 0);
            btn_stop  = ($urandom_range(0, 59) == 0);
            btn_pause = ($urandom_range(0, 24) == 0);
            tmr_done  = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 29) == 0) door_open = ~door_open;
            if ($urandom_range(0, 19) == 0) begin
                preset  = 2'($urandom_range(0, 3));
                man_min = 7'($urandom_range(0, 127));
                man_sec = 7'($urandom_range(0, 127));
                power   = 4'($urandom_range(0, 15));
            end
            reset = ($urandom_range(0, 299) == 0);
            clk_step();
        end
        reset = 1'b0; btn_start = 1'b0; btn_stop = 1'b0; btn_pause = 1'b0; tmr_done = 1'b0;
        run(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
